cp0_reg: RTL and testbench
==========================

# cp0_reg

Coprocessor-0 register file for the dual-issue MIPS core. It is the consumer of the exception arbiter's resolved outputs: it commits exceptions and `eret` into EPC/Cause/Status/BadVAddr. It also services MTC0/MFC0, runs the Count/Compare timer and presents live Status/Cause/EPC back to the arbiter. It sits beside the memory stage, and all state updates occur on the commit edge.

## Interface
- `PRID_VALUE`, 32'h0000_4220, read-only PRId contents
- `clk`  in  1  core clock
- `resetn`  in  1  asynchronous, active-low reset
- `we`  in  1  MTC0 write enable
- `waddr`  in  5  MTC0 register number
- `wdata`  in  32  MTC0 data
- `raddr`  in  5  MFC0 register number
- `rdata`  out  32  MFC0 data, combinational from current registers
- `ext_int`  in  6  external interrupt lines, level-sensitive
- `excepttype`  in  32  resolved exception code; 0 = none
- `except_inst_addr`  in  32  PC of the excepting instruction
- `except_bad_addr`  in  32  faulting address for codes 4/5
- `except_in_delayslot`  in  1  excepting instruction is in a delay slot
- `status_o`, `cause_o`, `epc_o`, `badvaddr_o`, `count_o`, `compare_o`  out  32 each  live register values
- `timer_int_o`  out  1  timer interrupt pending (Cause.TI)

## Operation
- Registers by number:
  - BadVAddr = 8 (read-only to software)
  - Count = 9
  - Compare = 11
  - Status = 12
  - Cause = 13
  - EPC = 14
  - PRId = 15 (read-only)
- Any other `raddr` returns 0. Writes to other or read-only numbers are ignored.
- Reset values:
  - Status = 32'h0040_0000 (BEV=1, EXL=0, IE=0)
  - Cause, EPC, BadVAddr, Count and Compare = 0
  - timer_int_o = 0
  - internal count tick = 0
- Writable fields:
  - Status: IM[15:8], EXL[1], IE[0]. Other bits hold their reset value.
  - Cause: IP[9:8] only.
  - Count, Compare, EPC: full 32 bits.
- Cause.IP[15:10] is resampled every edge as {ext_int[5] | timer_int, ext_int[4:0]}. Cause.TI[30] = timer_int_o.
- Count increments by 1 on every second `clk` edge: the tick toggles each edge, and Count increments on edges where tick==1. Count wraps from 32'hFFFF_FFFF to 0. An MTC0 to Count loads `wdata` and clears tick.
- Timer: timer_int_o is set on any edge where Count==Compare (registered values). An MTC0 to Compare clears it, and the clear wins over a simultaneous match.
- Exception commit (`excepttype` != 0, excluding 32'h0e):
  - If Status.EXL==0:
    - EPC <= `except_in_delayslot` ? `except_inst_addr` − 4 : `except_inst_addr`.
    - Cause.BD[31] <= `except_in_delayslot`.
  - If Status.EXL==1, EPC and BD are held.
  - Status.EXL <= 1.
  - Cause.ExcCode[6:2] <= (code==1) ? 0 : code[4:0].
  - For codes 4 and 5: BadVAddr <= `except_bad_addr`.
- ERET (`excepttype`==32'h0000_000e): Status.EXL <= 0. No other register changes.
- Priority: exception or ERET commit beats an MTC0 in the same cycle, and that MTC0 is dropped entirely. Count still ticks during an exception cycle.

## Timing
- All register updates land on the `clk` rising edge. Outputs reflect the new value in the following cycle.
- `rdata` and `*_o` are combinational from registers. There is no write-to-read bypass: an MFC0 in the same cycle as an MTC0 to the same register returns the old value.
- Latency from an `ext_int` change to Cause.IP: 1 edge.
- Latency from Count==Compare to `timer_int_o`: 1 edge.
- Asserting `resetn` low at any time forces all registers to their reset values immediately, independent of `clk`. This includes clearing a pending timer interrupt and the count tick.
- Deassertion is synchronous to design intent: the first counting edge is the second edge after release.

## Test plan
- Count/tick: release reset and run 10 edges → Count = 5. MTC0 Count=32'hFFFF_FFFF, then 2 edges → Count = 0.
- Timer: MTC0 Compare=8, Count=0, wait until Count reaches 8 → `timer_int_o`=1 one edge later and Cause[15]=1. MTC0 Compare=100 → `timer_int_o`=0 next cycle.
- Delay-slot exception: `excepttype`=4, inst_addr=32'hBFC0_0104, delayslot=1, bad_addr=32'h0000_0003 → EPC=32'hBFC0_0100, Cause.BD=1, ExcCode=4, BadVAddr=3, Status.EXL=1.
- Nested exception: with EXL=1, `excepttype`=8, inst_addr=32'h8000_0000 → EPC unchanged, ExcCode=8.
- ERET with simultaneous MTC0 Status=0 → EXL=0 and IM/IE unchanged (MTC0 dropped).
- Async reset mid-run: drop `resetn` between edges with Status=32'h0000_FF03 → Status=32'h0040_0000 and all other outputs 0 before the next edge.

Source files
------------

// File: rtl/cp0_reg_if.sv
// cp0_reg_if: MTC0/MFC0, exception-commit and live-register bundle between the core and CP0.
interface cp0_reg_if;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr;
   logic [31:0] rdata;
   logic [5:0]  ext_int;
   logic [31:0] excepttype;
   logic [31:0] except_inst_addr;
   logic [31:0] except_bad_addr;
   logic        except_in_delayslot;
   logic [31:0] status_o;
   logic [31:0] cause_o;
   logic [31:0] epc_o;
   logic [31:0] badvaddr_o;
   logic [31:0] count_o;
   logic [31:0] compare_o;
   logic        timer_int_o;
   modport master (
      output we, waddr, wdata, raddr, ext_int, excepttype, except_inst_addr, except_bad_addr,
             except_in_delayslot,
      input  rdata, status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o, timer_int_o
   );
   modport slave (
      input  we, waddr, wdata, raddr, ext_int, excepttype, except_inst_addr, except_bad_addr,
             except_in_delayslot,
      output rdata, status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o, timer_int_o
   );
endinterface

// File: rtl/cp0_reg.sv
// cp0_reg: coprocessor-0 register file committing exceptions/ERET, MTC0/MFC0 and the Count/Compare timer.
module cp0_reg #(
   parameter logic [31:0] PRID_VALUE = 32'h0000_4220
) (
   input logic       clk,
   input logic       resetn,
   cp0_reg_if.slave  bus
);
   logic [7:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [5:0]  ip_hw;
   logic [1:0]  ip_sw;
   logic [4:0]  exc_code;
   logic [31:0] epc;
   logic [31:0] badvaddr;
   logic [31:0] count;
   logic [31:0] compare;
   logic        tick;
   logic        timer_int;
   logic        eret;
   logic        exc;
   logic        wr;
   logic        wr_count;
   logic        wr_compare;
   logic        wr_status;
   logic        wr_cause;
   logic        wr_epc;
   logic        first_exc;
   logic        bad_addr_exc;
   logic [31:0] status;
   logic [31:0] cause;

   assign eret         = bus.excepttype == 32'h0000_000e;
   assign exc          = bus.excepttype != 32'd0 && !eret;
   // A committing exception or ERET drops any MTC0 issued in the same cycle.
   assign wr           = bus.we && !exc && !eret;
   assign wr_count     = wr && bus.waddr == 5'd9;
   assign wr_compare   = wr && bus.waddr == 5'd11;
   assign wr_status    = wr && bus.waddr == 5'd12;
   assign wr_cause     = wr && bus.waddr == 5'd13;
   assign wr_epc       = wr && bus.waddr == 5'd14;
   assign first_exc    = exc && !exl;
   assign bad_addr_exc = exc && (bus.excepttype == 32'd4 || bus.excepttype == 32'd5);

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         tick      <= 1'b0;
         count     <= 32'd0;
         compare   <= 32'd0;
         timer_int <= 1'b0;
      end else begin
         tick      <= wr_count ? 1'b0 : ~tick;
         count     <= wr_count ? bus.wdata : count + {31'd0, tick};
         compare   <= wr_compare ? bus.wdata : compare;
         timer_int <= wr_compare ? 1'b0 : (timer_int || count == compare);
      end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         im  <= 8'd0;
         exl <= 1'b0;
         ie  <= 1'b0;
      end else begin
         im  <= wr_status ? bus.wdata[15:8] : im;
         ie  <= wr_status ? bus.wdata[0] : ie;
         exl <= exc ? 1'b1 : eret ? 1'b0 : wr_status ? bus.wdata[1] : exl;
      end

   // EPC and BD only capture the outermost exception; nested ones keep the original return point.
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         epc      <= 32'd0;
         bd       <= 1'b0;
         exc_code <= 5'd0;
         badvaddr <= 32'd0;
         ip_hw    <= 6'd0;
         ip_sw    <= 2'd0;
      end else begin
         epc      <= first_exc ? (bus.except_in_delayslot ? bus.except_inst_addr - 32'd4 : bus.except_inst_addr)
                   : wr_epc ? bus.wdata : epc;
         bd       <= first_exc ? bus.except_in_delayslot : bd;
         exc_code <= exc ? (bus.excepttype == 32'd1 ? 5'd0 : bus.excepttype[4:0]) : exc_code;
         badvaddr <= bad_addr_exc ? bus.except_bad_addr : badvaddr;
         ip_hw    <= {bus.ext_int[5] | timer_int, bus.ext_int[4:0]};
         ip_sw    <= wr_cause ? bus.wdata[9:8] : ip_sw;
      end

   assign status = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
   assign cause  = {bd, timer_int, 14'd0, ip_hw, ip_sw, 1'b0, exc_code, 2'b00};

   assign bus.status_o    = status;
   assign bus.cause_o     = cause;
   assign bus.epc_o       = epc;
   assign bus.badvaddr_o  = badvaddr;
   assign bus.count_o     = count;
   assign bus.compare_o   = compare;
   assign bus.timer_int_o = timer_int;

   assign bus.rdata = bus.raddr == 5'd8  ? badvaddr
                    : bus.raddr == 5'd9  ? count
                    : bus.raddr == 5'd11 ? compare
                    : bus.raddr == 5'd12 ? status
                    : bus.raddr == 5'd13 ? cause
                    : bus.raddr == 5'd14 ? epc
                    : bus.raddr == 5'd15 ? PRID_VALUE
                    : 32'd0;
endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed vector table plus hand sequences for tick, timer and async reset.
module tb_cp0_reg;
   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  raddr;
      logic [5:0]  ext;
      logic [31:0] exc;
      logic [31:0] ia;
      logic [31:0] ba;
      logic        ds;
      logic        pre_en;
      logic [31:0] pre;
      logic [31:0] post;
   } vec_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;
   vec_t vecs[$];

   cp0_reg_if bus ();

   cp0_reg #(.PRID_VALUE(32'h0000_4220)) dut (.clk(clk), .resetn(resetn), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.we = 1'b0;
      bus.waddr = 5'd0;
      bus.wdata = 32'd0;
      bus.ext_int = 6'd0;
      bus.excepttype = 32'd0;
      bus.except_inst_addr = 32'd0;
      bus.except_bad_addr = 32'd0;
      bus.except_in_delayslot = 1'b0;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.we = 1'b1;
      bus.waddr = a;
      bus.wdata = d;
      @(negedge clk);
      idle();
   endtask

   initial begin
      idle();
      bus.raddr = 5'd15;
      repeat (2) @(negedge clk);
      check("rst_status", bus.status_o, 32'h0040_0000);
      check("rst_cause", bus.cause_o, 32'd0);
      check("rst_epc", bus.epc_o, 32'd0);
      check("rst_badvaddr", bus.badvaddr_o, 32'd0);
      check("rst_count", bus.count_o, 32'd0);
      check("rst_compare", bus.compare_o, 32'd0);
      check("rst_timer", {31'd0, bus.timer_int_o}, 32'd0);
      check("rst_prid", bus.rdata, 32'h0000_4220);
      resetn = 1'b1;
      repeat (10) @(negedge clk);
      check("count_10_edges", bus.count_o, 32'd5);
      mtc0(5'd9, 32'hFFFF_FFFF);
      check("count_load", bus.count_o, 32'hFFFF_FFFF);
      repeat (2) @(negedge clk);
      check("count_wrap", bus.count_o, 32'd0);

      vecs.push_back('{1'b1, 5'd11, 32'hFFFF_0000, 5'd11, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'hFFFF_0000});
      vecs.push_back('{1'b1, 5'd12, 32'hFFFF_FF01, 5'd12, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0040_0000, 32'h0040_FF01});
      vecs.push_back('{1'b1, 5'd14, 32'h1234_5678, 5'd14, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'h1234_5678});
      vecs.push_back('{1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'h0000_0300});
      vecs.push_back('{1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0});
      vecs.push_back('{1'b1, 5'd15, 32'd0, 5'd15, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_4220});
      vecs.push_back('{1'b1, 5'd3, 32'hFFFF_FFFF, 5'd3, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0});
      vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd13, 6'b100101, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_9700});
      vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd14, 6'd0, 32'd4, 32'hBFC0_0104, 32'd3, 1'b1, 1'b1, 32'h1234_5678, 32'hBFC0_0100});
      vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd13, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h8000_0310});
      vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd8, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd3});
      vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd12, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0040_FF03});
      vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd14, 6'd0, 32'd8, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 32'd0, 32'hBFC0_0100});
      vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd13, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h8000_0320});
      vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd8, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd3});
      vecs.push_back('{1'b1, 5'd12, 32'd0, 5'd12, 6'd0, 32'h0000_000e, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0040_FF03, 32'h0040_FF01});
      vecs.push_back('{1'b1, 5'd14, 32'h1111_1111, 5'd14, 6'd0, 32'd1, 32'h0000_0200, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_0200});
      vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd13, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_0300});
      vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd12, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0040_FF03});
      vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd12, 6'd0, 32'h0000_000e, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0040_FF01});
      vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd8, 6'd0, 32'd5, 32'h0000_0100, 32'hCAFE_F00D, 1'b0, 1'b0, 32'd0, 32'hCAFE_F00D});
      vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd14, 6'd0, 32'h0000_000e, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_0100});

      foreach (vecs[i]) begin
         bus.we = vecs[i].we;
         bus.waddr = vecs[i].waddr;
         bus.wdata = vecs[i].wdata;
         bus.raddr = vecs[i].raddr;
         bus.ext_int = vecs[i].ext;
         bus.excepttype = vecs[i].exc;
         bus.except_inst_addr = vecs[i].ia;
         bus.except_bad_addr = vecs[i].ba;
         bus.except_in_delayslot = vecs[i].ds;
         #1;
         if (vecs[i].pre_en) check($sformatf("vec%0d_pre", i), bus.rdata, vecs[i].pre);
         @(negedge clk);
         check($sformatf("vec%0d_post", i), bus.rdata, vecs[i].post);
         idle();
      end

      mtc0(5'd11, 32'd8);
      mtc0(5'd9, 32'd0);
      for (int i = 0; i < 100 && bus.count_o != 32'd8; i++) @(negedge clk);
      check("timer_count_reach", bus.count_o, 32'd8);
      check("timer_not_yet", {31'd0, bus.timer_int_o}, 32'd0);
      @(negedge clk);
      check("timer_set", {31'd0, bus.timer_int_o}, 32'd1);
      check("timer_cause_ti", {31'd0, bus.cause_o[30]}, 32'd1);
      @(negedge clk);
      check("timer_cause_ip7", {31'd0, bus.cause_o[15]}, 32'd1);
      mtc0(5'd11, 32'd100);
      check("timer_clear", {31'd0, bus.timer_int_o}, 32'd0);
      mtc0(5'd9, 32'd100);
      @(negedge clk);
      check("timer_reset_pending", {31'd0, bus.timer_int_o}, 32'd1);

      mtc0(5'd12, 32'h0000_FF03);
      check("pre_areset_status", bus.status_o, 32'h0040_FF03);
      #2 resetn = 1'b0;
      #1;
      check("areset_status", bus.status_o, 32'h0040_0000);
      check("areset_cause", bus.cause_o, 32'd0);
      check("areset_epc", bus.epc_o, 32'd0);
      check("areset_badvaddr", bus.badvaddr_o, 32'd0);
      check("areset_count", bus.count_o, 32'd0);
      check("areset_compare", bus.compare_o, 32'd0);
      check("areset_timer", {31'd0, bus.timer_int_o}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("release_first_edge", bus.count_o, 32'd0);
      @(negedge clk);
      check("release_second_edge", bus.count_o, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
